// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward sequencer for the 5-stage core.
// Handles the boot hold-off, load-use bubbles, data-memory waits, redirects and
// operand forwarding. Hazard outputs are zero-latency; perf counters are registered.
module pipeline_hazard_ctrl #(
   parameter int unsigned BOOT_HOLD = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       fetch_rs1,
   input  logic [4:0]       fetch_rs2,
   input  logic [4:0]       decode_rs1,
   input  logic [4:0]       decode_rs2,
   input  logic [4:0]       decode_rd,
   input  logic [1:0]       decode_result_src,
   input  logic [4:0]       mem_rd,
   input  logic             mem_wr_en,
   input  logic [4:0]       wb_rd,
   input  logic             wb_wr_en,
   input  logic             ex_pc_src,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             stall_fetch,
   output logic             stall_decode,
   output logic             flush_decode,
   output logic             flush_execute,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned BOOT_W = 4;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] SRC_LOAD = 2'b01;

   typedef enum logic [1:0] {
      ST_BOOT       = 2'd0,
      ST_RUN        = 2'd1,
      ST_LOAD_STALL = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BOOT_W-1:0] boot_cnt;
   logic              boot_done_c;
   logic              load_use_c;
   logic              mem_stall_c;
   logic              redirect_c;

   // Hazard conditions shared by next-state and output logic; x0 never creates a hazard.
   always_comb begin
      boot_done_c = (boot_cnt == BOOT_W'(BOOT_HOLD - 1));
      mem_stall_c = dmem_req && !dmem_ack;
      load_use_c  = (decode_result_src == SRC_LOAD) && (decode_rd != 5'd0) &&
                    ((decode_rd == fetch_rs1) || (decode_rd == fetch_rs2));
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) state <= ST_BOOT;
      else       state <= state_nxt;
   end

   // Next-state logic; a pending memory access wins over a redirect, a redirect over load-use.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: begin
            if (boot_done_c) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (mem_stall_c)                  state_nxt = ST_MEM_WAIT;
            else if (!ex_pc_src && load_use_c) state_nxt = ST_LOAD_STALL;
         end
         ST_LOAD_STALL: begin
            if (mem_stall_c) state_nxt = ST_MEM_WAIT;
            else             state_nxt = ST_RUN;
         end
         ST_MEM_WAIT: begin
            if (dmem_ack) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_BOOT;
      endcase
   end

   // Stall/flush outputs; redirects are only accepted while the pipe is free to move.
   always_comb begin
      stall_fetch   = 1'b0;
      stall_decode  = 1'b0;
      flush_decode  = 1'b0;
      flush_execute = 1'b0;
      redirect_c    = 1'b0;
      case (state)
         ST_BOOT: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            flush_decode = 1'b1;
         end
         ST_RUN: begin
            if (mem_stall_c) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
            end else if (ex_pc_src) begin
               flush_decode  = 1'b1;
               flush_execute = 1'b1;
               redirect_c    = 1'b1;
            end else if (load_use_c) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
               flush_decode = 1'b1;
            end
         end
         ST_LOAD_STALL: begin
            // The bubble is already in flight; only a new memory wait can freeze the pipe.
            if (mem_stall_c) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
            end else if (ex_pc_src) begin
               flush_decode  = 1'b1;
               flush_execute = 1'b1;
               redirect_c    = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!dmem_ack) begin
               stall_fetch  = 1'b1;
               stall_decode = 1'b1;
            end
         end
         default: begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
         end
      endcase
   end

   // Operand forwarding into execute; mem stage has priority over writeback.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (state != ST_BOOT) begin
         if (mem_wr_en && (mem_rd != 5'd0) && (mem_rd == decode_rs1))
            fwd_a = FWD_MEM;
         else if (wb_wr_en && (wb_rd != 5'd0) && (wb_rd == decode_rs1))
            fwd_a = FWD_WB;
         if (mem_wr_en && (mem_rd != 5'd0) && (mem_rd == decode_rs2))
            fwd_b = FWD_MEM;
         else if (wb_wr_en && (wb_rd != 5'd0) && (wb_rd == decode_rs2))
            fwd_b = FWD_WB;
      end
   end

   // Boot hold-off counter; cleared by reset so every reset repeats the full hold.
   always_ff @(posedge clk) begin
      if (!rstn)
         boot_cnt <= '0;
      else if ((state == ST_BOOT) && !boot_done_c)
         boot_cnt <= boot_cnt + BOOT_W'(1);
   end

   // Perf counters; frozen in BOOT, wrap silently.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if ((state != ST_BOOT) && stall_fetch)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (redirect_c)
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of boot hold-off, load-use, forwarding,
// redirect, memory wait and mid-operation reset.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W = 32;

   logic             clk;
   logic             rstn;
   logic [4:0]       fetch_rs1, fetch_rs2;
   logic [4:0]       decode_rs1, decode_rs2, decode_rd;
   logic [1:0]       decode_result_src;
   logic [4:0]       mem_rd, wb_rd;
   logic             mem_wr_en, wb_wr_en;
   logic             ex_pc_src, dmem_req, dmem_ack;
   logic             stall_fetch, stall_decode, flush_decode, flush_execute;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(.BOOT_HOLD(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn),
      .fetch_rs1(fetch_rs1), .fetch_rs2(fetch_rs2),
      .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
      .decode_result_src(decode_result_src),
      .mem_rd(mem_rd), .mem_wr_en(mem_wr_en), .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .ex_pc_src(ex_pc_src), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .flush_decode(flush_decode), .flush_execute(flush_execute),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      fetch_rs1 = 5'd0; fetch_rs2 = 5'd0;
      decode_rs1 = 5'd0; decode_rs2 = 5'd0; decode_rd = 5'd0;
      decode_result_src = 2'b00;
      mem_rd = 5'd0; mem_wr_en = 1'b0; wb_rd = 5'd0; wb_wr_en = 1'b0;
      ex_pc_src = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
   endtask

   // Inputs change at negedge; outputs sampled 1ns later, well before the next posedge.
   task automatic test_reset();
      rstn = 1'b0;
      set_idle();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (stall_fetch !== (k < 4)) begin
            errors++;
            $display("FAIL reset_stall_fetch k=%0d got %b exp %b", k, stall_fetch, (k < 4));
         end
         if (k == 0) begin
            checks++;
            if (flush_decode !== 1'b1 || flush_execute !== 1'b0 || stall_decode !== 1'b1) begin
               errors++;
               $display("FAIL reset_boot_outputs got fd=%b fe=%b sd=%b exp 1 0 1",
                        flush_decode, flush_execute, stall_decode);
            end
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (stall_cycles !== '0 || flush_count !== '0) begin
         errors++;
         $display("FAIL reset_counters got %0d %0d exp 0 0", stall_cycles, flush_count);
      end
   endtask

   task automatic test_load_use();
      // Load to x0 never stalls.
      decode_result_src = 2'b01; decode_rd = 5'd0; fetch_rs1 = 5'd0;
      #1;
      checks++;
      if (stall_fetch !== 1'b0) begin
         errors++;
         $display("FAIL load_use_x0 got stall %b exp 0", stall_fetch);
      end
      @(negedge clk);
      decode_result_src = 2'b01; decode_rd = 5'd5; fetch_rs1 = 5'd5;
      #1;
      checks++;
      if ({stall_fetch, stall_decode, flush_decode, flush_execute} !== 4'b1110) begin
         errors++;
         $display("FAIL load_use_bubble got %b exp 1110",
                  {stall_fetch, stall_decode, flush_decode, flush_execute});
      end
      @(negedge clk);
      set_idle();
      decode_rs1 = 5'd5; wb_rd = 5'd5; wb_wr_en = 1'b1;
      #1;
      checks++;
      if (stall_fetch !== 1'b0 || fwd_a !== 2'b01) begin
         errors++;
         $display("FAIL load_stall_fwd got stall %b fwd_a %b exp 0 01", stall_fetch, fwd_a);
      end
      checks++;
      if (stall_cycles !== 32'd1) begin
         errors++;
         $display("FAIL load_use_stall_cycles got %0d exp 1", stall_cycles);
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_forward();
      decode_rs2 = 5'd7; mem_rd = 5'd7; mem_wr_en = 1'b1; wb_rd = 5'd7; wb_wr_en = 1'b1;
      #1;
      checks++;
      if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
         errors++;
         $display("FAIL fwd_mem_priority got a=%b b=%b exp 00 10", fwd_a, fwd_b);
      end
      mem_wr_en = 1'b0;
      #1;
      checks++;
      if (fwd_b !== 2'b01) begin
         errors++;
         $display("FAIL fwd_wb got %b exp 01", fwd_b);
      end
      decode_rs2 = 5'd0; mem_rd = 5'd0; mem_wr_en = 1'b1; wb_rd = 5'd0;
      #1;
      checks++;
      if (fwd_b !== 2'b00) begin
         errors++;
         $display("FAIL fwd_x0 got %b exp 00", fwd_b);
      end
      decode_rs1 = 5'd9; decode_rs2 = 5'd3; mem_rd = 5'd9; mem_wr_en = 1'b1;
      wb_rd = 5'd3; wb_wr_en = 1'b1;
      #1;
      checks++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b01 || stall_fetch !== 1'b0) begin
         errors++;
         $display("FAIL fwd_both got a=%b b=%b stall=%b exp 10 01 0", fwd_a, fwd_b, stall_fetch);
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_redirect();
      decode_result_src = 2'b01; decode_rd = 5'd6; fetch_rs1 = 5'd6; ex_pc_src = 1'b1;
      #1;
      checks++;
      if ({stall_fetch, stall_decode, flush_decode, flush_execute} !== 4'b0011) begin
         errors++;
         $display("FAIL redirect_over_load_use got %b exp 0011",
                  {stall_fetch, stall_decode, flush_decode, flush_execute});
      end
      @(negedge clk);
      // Still in RUN: a load-use on rs2 must now stall.
      set_idle();
      decode_result_src = 2'b01; decode_rd = 5'd6; fetch_rs2 = 5'd6;
      #1;
      checks++;
      if (flush_count !== 32'd1) begin
         errors++;
         $display("FAIL redirect_flush_count got %0d exp 1", flush_count);
      end
      checks++;
      if (stall_fetch !== 1'b1 || flush_execute !== 1'b0) begin
         errors++;
         $display("FAIL redirect_stayed_run got stall %b fe %b exp 1 0", stall_fetch, flush_execute);
      end
      @(negedge clk);
      set_idle();
      @(negedge clk);
   endtask

   task automatic test_mem_wait();
      dmem_req = 1'b1; dmem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ex_pc_src = (k == 1);
         #1;
         checks++;
         if ({stall_fetch, stall_decode, flush_decode, flush_execute} !== 4'b1100) begin
            errors++;
            $display("FAIL mem_wait_freeze k=%0d got %b exp 1100", k,
                     {stall_fetch, stall_decode, flush_decode, flush_execute});
         end
         @(negedge clk);
      end
      ex_pc_src = 1'b0; dmem_ack = 1'b1;
      #1;
      checks++;
      if (stall_fetch !== 1'b0) begin
         errors++;
         $display("FAIL mem_wait_ack got stall %b exp 0", stall_fetch);
      end
      @(negedge clk);
      set_idle();
      #1;
      checks++;
      if (stall_cycles !== 32'd5 || flush_count !== 32'd1) begin
         errors++;
         $display("FAIL mem_wait_counters got %0d %0d exp 5 1", stall_cycles, flush_count);
      end
      checks++;
      if (stall_fetch !== 1'b0) begin
         errors++;
         $display("FAIL mem_wait_back_to_run got stall %b exp 0", stall_fetch);
      end
   endtask

   task automatic test_reset_mid();
      dmem_req = 1'b1; dmem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      set_idle();
      rstn = 1'b1;
      #1;
      checks++;
      if (stall_cycles !== '0 || flush_count !== '0) begin
         errors++;
         $display("FAIL mid_reset_counters got %0d %0d exp 0 0", stall_cycles, flush_count);
      end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) #1;
         checks++;
         if (stall_fetch !== (k < 4)) begin
            errors++;
            $display("FAIL mid_reset_boot k=%0d got %b exp %b", k, stall_fetch, (k < 4));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forward();
      test_redirect();
      test_mem_wait();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
